uart_rx: RTL

- Asynchronous serial receiver; the receive counterpart of the team's uart_tx.
- Frame format: line idles high; 1 start bit (low); WIDTH data bits, LSB first; 1 stop bit (high); each bit is DIVISOR clk cycles.
- Oversamples i_rx at clk rate, validates the start bit at mid-bit, samples each data bit at its centre, checks the stop bit.
- Presents each received word with a single-cycle valid pulse; sits between the board RX pin and the consumer logic (command parser / FIFO).

---
 rtl/uart_pkg.sv | 19 +
 rtl/counter.sv | 22 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and bit-timing helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    function automatic int unsigned bit_period_half(input int unsigned divisor);
        return divisor / 2;
    endfunction

endpackage

// File: rtl/counter.sv
// Free-running up-counter wrapping at MAX_VALUE, with synchronous active-high clear.
module counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 15
) (
    input  logic             clk,
    input  logic             i_reset,
    output logic [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_VALUE);

    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (o_count == LAST) begin
            o_count <= '0;
        end else begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit start validation, centre-sampled
// LSB-first data, stop-bit check with single-cycle o_dv / o_frame_err pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIVISOR = 100
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_frame_err,
    output logic             o_busy
);
    localparam int unsigned   CW       = $clog2(DIVISOR);
    localparam int unsigned   BW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(bit_period_half(DIVISOR) - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic              rx_meta, rx_s, rx_s_d;
    logic [1:0]        sync_vld;
    logic              armed;
    uart_state_t       state, state_next;
    logic [CW-1:0]     cnt;
    logic              cnt_clr;
    logic [BW-1:0]     bit_idx;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH:0]    shift_in;
    logic              do_shift, frame_ok, frame_bad;

    counter #(
        .WIDTH     (CW),
        .MAX_VALUE (DIVISOR - 1)
    ) u_sample_cnt (
        .clk     (clk),
        .i_reset (cnt_clr),
        .o_count (cnt)
    );

    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        shift_in   = {rx_s, shreg};
        case (state)
            IDLE: begin
                if (armed && rx_s_d == UART_IDLE_LEVEL && rx_s == UART_START_LEVEL)
                    state_next = START;
            end
            START: begin
                if (cnt == CNT_HALF)
                    state_next = (rx_s == UART_START_LEVEL) ? DATA : IDLE;
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    do_shift = 1'b1;
                    if (bit_idx == BIT_LAST)
                        state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_FULL) begin
                    if (rx_s == UART_IDLE_LEVEL) begin
                        frame_ok   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s == UART_IDLE_LEVEL)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        cnt_clr = i_reset || (state_next != state);
        o_busy  = (state == START) || (state == DATA) || (state == STOP);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_s_d      <= 1'b1;
            sync_vld    <= '0;
            armed       <= 1'b0;
            state       <= IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta  <= i_rx;
            rx_s     <= rx_meta;
            rx_s_d   <= rx_s;
            sync_vld <= {sync_vld[0], 1'b1};
            // The sync flops reset high, so a line already low at reset release would
            // look like a falling edge; starts are only accepted once a real high is seen.
            if (sync_vld[1] && rx_s == UART_IDLE_LEVEL)
                armed <= 1'b1;
            state <= state_next;
            if (state == START)
                bit_idx <= '0;
            else if (do_shift)
                bit_idx <= bit_idx + 1'b1;
            if (do_shift)
                shreg <= shift_in[WIDTH:1];
            o_dv        <= frame_ok;
            o_frame_err <= frame_bad;
            if (frame_ok)
                o_data <= shreg;
        end
    end

endmodule
